// File: rtl/jt10_adpcmb_lerp.sv
// Linear interpolator between successive ADPCM-B samples, with its restoring divider.
// Optional round-half-up of the per-tick step: define JT10_LERP_ROUND_EN.

module jt10_adpcm_div #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] d,
  output logic [DW-1:0] r,
  output logic          working
);
  localparam int IW = $clog2(DW);

  logic [DW-1:0] q_q, q_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          armed_q, armed_d;
  logic          working_q, working_d;
  logic [DW:0]   shifted;
  logic [DW:0]   trial;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    q_d       = q_q;
    rem_d     = rem_q;
    div_d     = div_q;
    iter_d    = iter_q;
    armed_d   = armed_q;
    working_d = working_q;
    shifted   = {rem_q, q_q[DW-1]};
    trial     = shifted - {1'b0, div_q};
    if (cen) begin
      if (start) begin
        q_d       = a;
        rem_d     = '0;
        div_d     = b;
        iter_d    = '0;
        armed_d   = 1'b1;
        working_d = 1'b0;
      end else if (armed_q) begin
        // working is raised with the first iteration, one cen after start
        if (!trial[DW]) begin
          rem_d = trial[DW-1:0];
          q_d   = {q_q[DW-2:0], 1'b1};
        end else begin
          rem_d = shifted[DW-1:0];
          q_d   = {q_q[DW-2:0], 1'b0};
        end
        iter_d    = iter_q + IW'(1);
        working_d = 1'b1;
        if (iter_q == IW'(DW - 1)) begin
          armed_d   = 1'b0;
          working_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      iter_q    <= '0;
      armed_q   <= 1'b0;
      working_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      iter_q    <= iter_d;
      armed_q   <= armed_d;
      working_q <= working_d;
    end
  end

  assign d       = q_q;
  assign r       = rem_q;
  assign working = working_q;
endmodule

module jt10_adpcmb_lerp #(
  parameter int CW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               cen55,
  input  logic               adv,
  input  logic signed [15:0] pcm_in,
  output logic signed [15:0] pcm_out,
  output logic               busy
);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] pcm_out_q, pcm_out_d;
  logic signed [15:0] tgt_q, tgt_d;
  logic [CW-1:0]      step_q, step_d;
  logic               step_neg_q, step_neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      per_q, per_d;
  logic [CW-1:0]      mag_q, mag_d;
  logic               sign_q, sign_d;
  logic               busy_q, busy_d;
  logic               wait_first_q, wait_first_d;

  logic               div_start;
  logic               div_working;
  logic [CW-1:0]      div_d_out;
  logic [CW-1:0]      div_r_out;
  logic [CW-1:0]      step_fin;
  logic signed [16:0] dlt;
  logic [CW-1:0]      mag;
  logic signed [17:0] ramp;
  logic signed [17:0] tgt_ext;
  logic               clamp;

  assign div_start = (state_q == ST_START);

  jt10_adpcm_div #(.DW(CW)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .start   (div_start),
    .a       (mag_q),
    .b       (per_q),
    .d       (div_d_out),
    .r       (div_r_out),
    .working (div_working)
  );

`ifdef JT10_LERP_ROUND_EN
  assign step_fin = ({div_r_out, 1'b0} >= {1'b0, per_q} && div_d_out != {CW{1'b1}})
                    ? div_d_out + CW'(1) : div_d_out;
`else
  logic unused_r;
  assign unused_r = ^div_r_out;
  assign step_fin = div_d_out;
`endif

  assign dlt = {pcm_in[15], pcm_in} - {tgt_q[15], tgt_q};
  assign mag = dlt[16] ? (~dlt[15:0] + 16'd1) : dlt[15:0];

  // 18-bit ramp so that a full-scale step cannot wrap before the clamp
  assign tgt_ext = {{2{tgt_q[15]}}, tgt_q};
  assign ramp    = step_neg_q ? ({{2{pcm_out_q[15]}}, pcm_out_q} - $signed({2'b00, step_q}))
                              : ({{2{pcm_out_q[15]}}, pcm_out_q} + $signed({2'b00, step_q}));
  assign clamp   = step_neg_q ? (ramp <= tgt_ext) : (ramp >= tgt_ext);

  always_comb begin
    state_d      = state_q;
    pcm_out_d    = pcm_out_q;
    tgt_d        = tgt_q;
    step_d       = step_q;
    step_neg_d   = step_neg_q;
    cnt_d        = cnt_q;
    per_d        = per_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    busy_d       = busy_q;
    wait_first_d = wait_first_q;
    if (cen) begin
      if (cen55 && cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
      if (adv) begin
        pcm_out_d    = tgt_q;
        tgt_d        = pcm_in;
        sign_d       = dlt[16];
        mag_d        = mag;
        per_d        = (cnt_q == '0) ? CW'(1) : cnt_q;
        cnt_d        = cen55 ? CW'(1) : '0;
        state_d      = ST_START;
        busy_d       = 1'b1;
        wait_first_d = 1'b0;
      end else begin
        case (state_q)
          ST_START: begin
            state_d      = ST_WAIT;
            wait_first_d = 1'b1;
          end
          ST_WAIT: begin
            if (wait_first_q) begin
              wait_first_d = 1'b0;
            end else if (!div_working) begin
              step_d     = step_fin;
              step_neg_d = sign_q;
              busy_d     = 1'b0;
              state_d    = ST_RUN;
            end
          end
          ST_RUN: begin
            if (cen55) pcm_out_d = clamp ? tgt_q : ramp[15:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pcm_out_q    <= '0;
      tgt_q        <= '0;
      step_q       <= '0;
      step_neg_q   <= 1'b0;
      cnt_q        <= '0;
      per_q        <= '0;
      mag_q        <= '0;
      sign_q       <= 1'b0;
      busy_q       <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcm_out_q    <= pcm_out_d;
      tgt_q        <= tgt_d;
      step_q       <= step_d;
      step_neg_q   <= step_neg_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      mag_q        <= mag_d;
      sign_q       <= sign_d;
      busy_q       <= busy_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign pcm_out = pcm_out_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_jt10_adpcmb_lerp.sv
// Directed bench for jt10_adpcmb_lerp: ramps, clamping, rounding, restart and reset.
module tb_jt10_adpcmb_lerp;
  logic               clk;
  logic               rst_n;
  logic               cen;
  logic               cen55;
  logic               adv;
  logic signed [15:0] pcm_in;
  logic signed [15:0] pcm_out;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  jt10_adpcmb_lerp #(.CW(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .cen55   (cen55),
    .adv     (adv),
    .pcm_in  (pcm_in),
    .pcm_out (pcm_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic a, input logic signed [15:0] p, input logic t);
    adv    = a;
    pcm_in = p;
    cen55  = t;
    @(posedge clk);
    #1;
    adv   = 1'b0;
    cen55 = 1'b0;
  endtask

  task automatic do_adv(input logic signed [15:0] p, input logic signed [15:0] exp_out,
                        input string name);
    cycle(1'b1, p, 1'b0);
    checks++;
    if (pcm_out !== exp_out || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s: pcm_out=%0d busy=%b, required pcm_out=%0d busy=1",
               name, pcm_out, busy, exp_out);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      cycle(1'b0, 16'sd0, 1'b0);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic ticks(input logic signed [15:0] exp_v [], input string name);
    foreach (exp_v[i]) begin
      cycle(1'b0, 16'sd0, 1'b1);
      checks++;
      if (pcm_out !== exp_v[i]) begin
        failures++;
        $display("FAIL %s[%0d]: pcm_out=%0d, required %0d", name, i, pcm_out, exp_v[i]);
      end
    end
  endtask

  task automatic latency(input string name);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 16'sd0, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s: busy=%b at cycle %0d after adv, required 1", name, busy, i + 1);
      end
    end
    cycle(1'b0, 16'sd0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b at cycle 18 after adv, required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (pcm_out !== 16'sd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: pcm_out=%0d busy=%b, required 0 0", pcm_out, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'sd0, 1'b1);
      checks++;
      if (pcm_out !== 16'sd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: pcm_out=%0d busy=%b, required 0 0", pcm_out, busy);
      end
    end
  endtask

  task automatic test_ramp_up;
    logic signed [15:0] e [];
    do_adv(16'sd0, 16'sd0, "up_adv0");
    wait_done("up_wait0");
    e = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    ticks(e, "up_flat");
    do_adv(16'sd400, 16'sd0, "up_adv400");
    latency("up_latency");
    e = '{16'sd100, 16'sd200};
    ticks(e, "up_ramp_a");
    cen = 1'b0;
    cycle(1'b0, 16'sd0, 1'b1);
    cen = 1'b1;
    checks++;
    if (pcm_out !== 16'sd200) begin
      failures++;
      $display("FAIL up_cen_low: pcm_out=%0d, required 200", pcm_out);
    end
    e = '{16'sd300, 16'sd400, 16'sd400, 16'sd400};
    ticks(e, "up_ramp_b");
  endtask

  task automatic test_ramp_down;
    logic signed [15:0] e [];
    do_adv(16'sd400, 16'sd400, "dn_adv400");
    wait_done("dn_wait0");
    e = '{16'sd400, 16'sd400, 16'sd400, 16'sd400};
    ticks(e, "dn_flat");
    do_adv(-16'sd400, 16'sd400, "dn_adv_neg");
    wait_done("dn_wait1");
    e = '{16'sd200, 16'sd0, -16'sd200, -16'sd400, -16'sd400};
    ticks(e, "dn_ramp");
  endtask

  task automatic test_round;
    logic signed [15:0] e [];
    do_adv(16'sd0, -16'sd400, "rnd_adv0");
    wait_done("rnd_wait0");
    e = '{-16'sd320, -16'sd240, -16'sd160, -16'sd80};
    ticks(e, "rnd_pre");
    do_adv(16'sd10, 16'sd0, "rnd_adv10");
    wait_done("rnd_wait1");
`ifdef JT10_LERP_ROUND_EN
    e = '{16'sd3, 16'sd6, 16'sd9, 16'sd10, 16'sd10};
`else
    e = '{16'sd2, 16'sd4, 16'sd6, 16'sd8, 16'sd10};
`endif
    ticks(e, "rnd_ramp");
  endtask

  task automatic test_per_one;
    logic signed [15:0] e [];
    do_adv(-16'sd32768, 16'sd10, "per1_adv_min");
    wait_done("per1_wait0");
    do_adv(16'sd32767, -16'sd32768, "per1_adv_max");
    wait_done("per1_wait1");
    e = '{16'sd32767, 16'sd32767};
    ticks(e, "per1_clamp");
  endtask

  task automatic test_adv_in_wait;
    logic signed [15:0] e [];
    do_adv(16'sd0, 16'sd32767, "rst_div_adv0");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 16'sd0, (i < 4));
      checks++;
      if (busy !== 1'b1 || pcm_out !== 16'sd32767) begin
        failures++;
        $display("FAIL wait_hold[%0d]: pcm_out=%0d busy=%b, required 32767 1", i, pcm_out, busy);
      end
    end
    do_adv(16'sd100, 16'sd0, "restart_adv100");
    latency("restart_latency");
    e = '{16'sd25, 16'sd50, 16'sd75, 16'sd100, 16'sd100};
    ticks(e, "restart_ramp");
  endtask

  task automatic test_reset_mid;
    logic signed [15:0] e [];
    do_adv(-16'sd100, 16'sd100, "rst_adv");
    wait_done("rst_wait0");
    e = '{16'sd60};
    ticks(e, "rst_pre");
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        do_adv(16'sd50, 16'sd0, "rst_adv_wait");
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'sd0, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (pcm_out !== 16'sd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_async[%0d]: pcm_out=%0d busy=%b, required 0 0", k, pcm_out, busy);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cycle(1'b0, 16'sd0, 1'b1);
        checks++;
        if (pcm_out !== 16'sd0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL rst_idle[%0d]: pcm_out=%0d busy=%b, required 0 0", k, pcm_out, busy);
        end
      end
    end
    do_adv(16'sd200, 16'sd0, "rst_after_adv");
    wait_done("rst_after_wait");
    e = '{16'sd50, 16'sd100, 16'sd150, 16'sd200};
    ticks(e, "rst_after_ramp");
  endtask

  initial begin
    rst_n  = 1'b0;
    cen    = 1'b1;
    cen55  = 1'b0;
    adv    = 1'b0;
    pcm_in = 16'sd0;
    #12;
    test_reset;
    test_ramp_up;
    test_ramp_down;
    test_round;
    test_per_one;
    test_adv_in_wait;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
